player_life_ctrl: RTL and testbench
===================================

# player_life_ctrl

Tracks the player's remaining lives, post-hit invincibility and sprite blink during a game. It is the producer of the `player_die` level that the game-state FSM consumes. It sits between collision detection (`hit`) and power-up logic (`bonus`) upstream, and the game FSM and sprite renderer downstream. It is armed only while the game FSM reports the in-game screen.

## Interface
- `LIVES`, default 3: lives granted at game start; must be 1..MAX_LIVES.
- `MAX_LIVES`, default 5: saturation ceiling for `lives`.
- `INVULN_FRAMES`, default 120: invincibility length in frames, applied at spawn and after each survivable hit; must be ≥1.
- `BLINK_FRAMES`, default 8: frames per half-period of the blink; must be ≥1.
- `Clk` in 1: system clock. One clock domain.
- `Reset` in 1: synchronous, active-high.
- `game_active` in 1: high while the game FSM is in its in-game state (its `game_screen` output).
- `frame_tick` in 1: one-cycle pulse per video frame, already synchronous to `Clk`.
- `hit` in 1: collision with a meteorite this cycle; sampled every cycle.
- `bonus` in 1: extra-life pickup this cycle; sampled every cycle.
- `lives` out LW = $clog2(MAX_LIVES+1): remaining lives.
- `player_die` out 1: level; high from death until `game_active` falls.
- `invincible` out 1: high while hits are ignored.
- `visible` out 1: sprite draw enable.

## Operation
- States: IDLE, INVULN, ALIVE, DEAD.
- IDLE:
  - `lives`=LIVES, `player_die`=0, `invincible`=0, `visible`=1.
  - `hit` and `bonus` are ignored.
  - `game_active`=1 → INVULN with timer=INVULN_FRAMES. This is spawn protection.
- ALIVE:
  - Compute net = min(lives + bonus, MAX_LIVES) − hit.
  - hit with net=0 → DEAD, `lives`=0.
  - hit with net>0 → INVULN, `lives`=net, timer=INVULN_FRAMES.
  - No hit → `lives`=net.
- INVULN:
  - `hit` is ignored. `bonus` applies with saturation.
  - Each `frame_tick` decrements the timer.
  - A tick while timer=1 → ALIVE.
- DEAD: `player_die`=1, `visible`=0, `lives`=0. `bonus` is ignored.
- Any state with `game_active`=0 → IDLE. This overrides `hit`, `bonus` and `frame_tick` in the same cycle.
- Blink:
  - On entering INVULN: blink counter cleared, `visible`=1.
  - Every BLINK_FRAMES ticks in INVULN, `visible` toggles.
  - On leaving INVULN, `visible` returns to 1 (ALIVE) or 0 (DEAD).
- Arithmetic:
  - `lives` never exceeds MAX_LIVES and never goes below 0.
  - Timer width is $clog2(INVULN_FRAMES+1). Timer holds 0 outside INVULN.

## Timing
- All outputs are registered and change on the edge after the causing input cycle, with 1-cycle latency.
- Reset values: state IDLE, `lives`=LIVES, `player_die`=0, `invincible`=0, `visible`=1, timer 0, blink counter 0.
- `invincible`=1 exactly while in INVULN.
- INVULN lasts exactly INVULN_FRAMES `frame_tick` pulses after entry. A tick coincident with the entering cycle is not counted.
- `Reset` mid-game: IDLE on the next edge regardless of other inputs. Re-entry to INVULN happens only after IDLE has been held for at least one cycle with `game_active`=1.
- `hit` held high for many cycles in ALIVE costs exactly one life, because the next cycle is already INVULN.
- `player_die` falls the cycle after `game_active` falls.

## Structure
- Shared package `game_pkg` holds:
  - the `life_state_t` enum (IDLE, INVULN, ALIVE, DEAD);
  - default constants for LIVES, MAX_LIVES, INVULN_FRAMES and BLINK_FRAMES.
- Sub-module `frame_timer` is a loadable down-counter.
  - Inputs: `Clk`, `Reset`, `load`, `load_val`, `frame_tick`.
  - Output: `expire`, pulsed on the tick that takes the count from 1 to 0.
  - It is instantiated twice: once for invincibility and once, reloaded with BLINK_FRAMES on each expire, for blink.
- FSM, lives arithmetic and output registers stay in the top.

## Test plan
Parameters for all scenarios: LIVES=3, MAX_LIVES=5, INVULN_FRAMES=4, BLINK_FRAMES=2.
- Reset, then `game_active`=1 → next cycle `invincible`=1, `lives`=3. After the 4th `frame_tick`, `invincible`=0 and state is ALIVE.
- 1-cycle `hit` in ALIVE → `lives`=2, `invincible`=1. A `hit` during INVULN leaves `lives`=2.
- Three hits separated by full INVULN periods → `lives` 2, 1, 0. `player_die`=1 the cycle after the 3rd hit and holds. `game_active`=0 → next cycle `player_die`=0, `lives`=3.
- `bonus` at `lives`=5 → stays 5. `hit`+`bonus` in the same cycle at `lives`=1 → `lives`=1, INVULN, `player_die`=0.
- Blink: `visible` over INVULN ticks 0..4 reads 1,1,0,0,1, then 1 in ALIVE. `visible`=0 in DEAD.
- `Reset` asserted mid-INVULN with `game_active`=1 → next cycle IDLE, `lives`=3, `invincible`=0. The following cycle it re-enters INVULN.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game definitions: player life states and default tuning constants.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        INVULN,
        ALIVE,
        DEAD
    } life_state_t;

    localparam int unsigned DEF_LIVES         = 3;
    localparam int unsigned DEF_MAX_LIVES     = 5;
    localparam int unsigned DEF_INVULN_FRAMES = 120;
    localparam int unsigned DEF_BLINK_FRAMES  = 8;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter. expire pulses on the frame tick that takes
// the count from 1 to 0; a load in the same cycle wins over the tick.
module frame_timer #(
    parameter int unsigned W = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame_tick,
    output logic         expire
);

    logic [W-1:0] count;

    // expire is independent of load so the owner may reload on expire
    assign expire = frame_tick && (count == W'(1));

    // Count register: load has priority, otherwise decrement on tick down to 0
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (frame_tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/player_life_ctrl.sv
// Player life controller: lives bookkeeping, post-hit invincibility window,
// sprite blink and the player_die level consumed by the game FSM.
module player_life_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES         = DEF_LIVES,
    parameter int unsigned MAX_LIVES     = DEF_MAX_LIVES,
    parameter int unsigned INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int unsigned BLINK_FRAMES  = DEF_BLINK_FRAMES,
    localparam int unsigned LW           = $clog2(MAX_LIVES + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          game_active,
    input  logic          frame_tick,
    input  logic          hit,
    input  logic          bonus,
    output logic [LW-1:0] lives,
    output logic          player_die,
    output logic          invincible,
    output logic          visible
);

    localparam int unsigned TW = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [LW:0] MAX_W = (LW + 1)'(MAX_LIVES);

    life_state_t   state;
    logic [LW:0]   sum;
    logic [LW:0]   sat;
    logic [LW:0]   net;
    logic          enter_invuln;
    logic          stay_invuln;
    logic          inv_load;
    logic [TW-1:0] inv_val;
    logic          inv_expire;
    logic          blink_load;
    logic [BW-1:0] blink_val;
    logic          blink_expire;

    // Lives arithmetic and timer control derived from the current state
    always_comb begin
        sum          = {1'b0, lives} + {{LW{1'b0}}, bonus};
        sat          = (sum > MAX_W) ? MAX_W : sum;
        net          = sat - {{LW{1'b0}}, hit};
        enter_invuln = game_active &&
                       ((state == IDLE) ||
                        ((state == ALIVE) && hit && (net != '0)));
        stay_invuln  = game_active && (state == INVULN) && !inv_expire;
        // Timers are held at zero whenever the FSM is not counting in INVULN
        inv_load     = !stay_invuln;
        inv_val      = enter_invuln ? TW'(INVULN_FRAMES) : '0;
        blink_load   = !stay_invuln || blink_expire;
        blink_val    = (enter_invuln || stay_invuln) ? BW'(BLINK_FRAMES) : '0;
    end

    frame_timer #(.W(TW)) u_invuln_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (inv_load),
        .load_val   (inv_val),
        .frame_tick (frame_tick),
        .expire     (inv_expire)
    );

    frame_timer #(.W(BW)) u_blink_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .load       (blink_load),
        .load_val   (blink_val),
        .frame_tick (frame_tick),
        .expire     (blink_expire)
    );

    // Life FSM with registered outputs; game_active low forces IDLE
    always_ff @(posedge Clk) begin
        if (Reset || !game_active) begin
            state      <= IDLE;
            lives      <= LW'(LIVES);
            player_die <= 1'b0;
            invincible <= 1'b0;
            visible    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    state      <= INVULN;
                    lives      <= LW'(LIVES);
                    invincible <= 1'b1;
                    visible    <= 1'b1;
                end
                INVULN: begin
                    lives <= sat[LW-1:0];
                    if (inv_expire) begin
                        state      <= ALIVE;
                        invincible <= 1'b0;
                        visible    <= 1'b1;
                    end else if (blink_expire) begin
                        visible <= ~visible;
                    end
                end
                ALIVE: begin
                    if (hit && (net == '0)) begin
                        state      <= DEAD;
                        lives      <= '0;
                        player_die <= 1'b1;
                        visible    <= 1'b0;
                    end else if (hit) begin
                        state      <= INVULN;
                        lives      <= net[LW-1:0];
                        invincible <= 1'b1;
                        visible    <= 1'b1;
                    end else begin
                        lives <= net[LW-1:0];
                    end
                end
                DEAD: begin
                    lives      <= '0;
                    player_die <= 1'b1;
                    invincible <= 1'b0;
                    visible    <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    lives      <= LW'(LIVES);
                    player_die <= 1'b0;
                    invincible <= 1'b0;
                    visible    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_life_ctrl.sv
// Self-checking bench for player_life_ctrl: directed scenarios against
// fixed expected values plus randomized traffic against a rule-level model.
module tb_player_life_ctrl;

    localparam int unsigned P_LIVES  = 3;
    localparam int unsigned P_MAX    = 5;
    localparam int unsigned P_INV    = 4;
    localparam int unsigned P_BLINK  = 2;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       game_active = 1'b0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       bonus = 1'b0;
    logic [2:0] lives;
    logic       player_die;
    logic       invincible;
    logic       visible;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0=idle 1=protected 2=alive 3=dead
    int m_mode  = 0;
    int m_lives = P_LIVES;
    int m_left  = 0;
    int m_blink = 0;
    int m_vis   = 1;

    player_life_ctrl #(
        .LIVES         (P_LIVES),
        .MAX_LIVES     (P_MAX),
        .INVULN_FRAMES (P_INV),
        .BLINK_FRAMES  (P_BLINK)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .game_active (game_active),
        .frame_tick  (frame_tick),
        .hit         (hit),
        .bonus       (bonus),
        .lives       (lives),
        .player_die  (player_die),
        .invincible  (invincible),
        .visible     (visible)
    );

    always #5 Clk = ~Clk;

    task automatic model_step(input int r, input int ga, input int tk, input int h, input int b);
        int boosted;
        if (r != 0 || ga == 0) begin
            m_mode = 0; m_lives = P_LIVES; m_left = 0; m_blink = 0; m_vis = 1;
        end else if (m_mode == 0) begin
            m_mode = 1; m_left = P_INV; m_blink = 0; m_vis = 1;
        end else if (m_mode == 1) begin
            m_lives = (m_lives + b > P_MAX) ? P_MAX : m_lives + b;
            if (tk != 0) begin
                m_left  = m_left - 1;
                m_blink = m_blink + 1;
                if (m_left == 0) begin
                    m_mode = 2; m_vis = 1; m_blink = 0;
                end else if (m_blink == P_BLINK) begin
                    m_vis = 1 - m_vis; m_blink = 0;
                end
            end
        end else if (m_mode == 2) begin
            boosted = (m_lives + b > P_MAX) ? P_MAX : m_lives + b;
            m_lives = boosted - h;
            if (h != 0 && m_lives == 0) begin
                m_mode = 3; m_vis = 0;
            end else if (h != 0) begin
                m_mode = 1; m_left = P_INV; m_blink = 0; m_vis = 1;
            end
        end else begin
            m_lives = 0;
        end
    endtask

    // One clock: drive inputs, take the edge, settle, advance the model
    task automatic cyc(input int r, input int ga, input int tk, input int h, input int b);
        Reset = (r != 0); game_active = (ga != 0); frame_tick = (tk != 0);
        hit = (h != 0); bonus = (b != 0);
        @(posedge Clk);
        #1;
        model_step(r, ga, tk, h, b);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 1, 0, 0, 0);
            cyc(0, 1, 1, 0, 0);
        end
    endtask

    task automatic go_alive();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        run_ticks(P_INV);
    endtask

    task automatic test_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        checks++; if (lives !== 3'd3) begin failures++; $display("FAIL reset_lives: got %0d want 3", lives); end
        checks++; if (player_die !== 1'b0) begin failures++; $display("FAIL reset_die: got %b want 0", player_die); end
        checks++; if (invincible !== 1'b0) begin failures++; $display("FAIL reset_inv: got %b want 0", invincible); end
        checks++; if (visible !== 1'b1) begin failures++; $display("FAIL reset_vis: got %b want 1", visible); end
    endtask

    task automatic test_spawn();
        cyc(0, 1, 1, 1, 0);  // tick and hit on the spawn cycle are not counted
        checks++; if (invincible !== 1'b1) begin failures++; $display("FAIL spawn_inv: got %b want 1", invincible); end
        checks++; if (lives !== 3'd3) begin failures++; $display("FAIL spawn_lives: got %0d want 3", lives); end
        run_ticks(P_INV - 1);
        checks++; if (invincible !== 1'b1) begin failures++; $display("FAIL spawn_inv_tick3: got %b want 1", invincible); end
        run_ticks(1);
        checks++; if (invincible !== 1'b0) begin failures++; $display("FAIL spawn_inv_end: got %b want 0", invincible); end
    endtask

    task automatic test_hit();
        go_alive();
        cyc(0, 1, 0, 1, 0);
        checks++; if (lives !== 3'd2) begin failures++; $display("FAIL hit_lives: got %0d want 2", lives); end
        checks++; if (invincible !== 1'b1) begin failures++; $display("FAIL hit_inv: got %b want 1", invincible); end
        cyc(0, 1, 1, 1, 0);
        cyc(0, 1, 0, 1, 0);
        checks++; if (lives !== 3'd2) begin failures++; $display("FAIL hit_ignored: got %0d want 2", lives); end
        run_ticks(P_INV - 1);
        checks++; if (invincible !== 1'b0) begin failures++; $display("FAIL hit_inv_end: got %b want 0", invincible); end
    endtask

    task automatic test_held_hit();
        go_alive();
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 0);
        checks++; if (lives !== 3'd2) begin failures++; $display("FAIL held_hit_lives: got %0d want 2", lives); end
        run_ticks(P_INV);
    endtask

    task automatic test_death();
        logic [2:0] want;
        go_alive();
        for (int i = 0; i < 3; i++) begin
            want = 3'(2 - i);
            cyc(0, 1, 0, 1, 0);
            checks++; if (lives !== want) begin failures++; $display("FAIL death_lives%0d: got %0d want %0d", i, lives, want); end
            if (i < 2) run_ticks(P_INV);
        end
        checks++; if (player_die !== 1'b1) begin failures++; $display("FAIL death_die: got %b want 1", player_die); end
        checks++; if (visible !== 1'b0) begin failures++; $display("FAIL death_vis: got %b want 0", visible); end
        for (int i = 0; i < 5; i++) cyc(0, 1, i % 2, 1, 1);
        checks++; if (player_die !== 1'b1) begin failures++; $display("FAIL death_hold: got %b want 1", player_die); end
        checks++; if (lives !== 3'd0) begin failures++; $display("FAIL death_bonus: got %0d want 0", lives); end
        cyc(0, 0, 1, 1, 1);
        checks++; if (player_die !== 1'b0) begin failures++; $display("FAIL death_release: got %b want 0", player_die); end
        checks++; if (lives !== 3'd3) begin failures++; $display("FAIL death_relives: got %0d want 3", lives); end
    endtask

    task automatic test_bonus_sat();
        go_alive();
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        checks++; if (lives !== 3'd5) begin failures++; $display("FAIL bonus_to_max: got %0d want 5", lives); end
        cyc(0, 1, 0, 0, 1);
        checks++; if (lives !== 3'd5) begin failures++; $display("FAIL bonus_sat: got %0d want 5", lives); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 1, 0);
            run_ticks(P_INV);
        end
        checks++; if (lives !== 3'd1) begin failures++; $display("FAIL bonus_down: got %0d want 1", lives); end
        cyc(0, 1, 0, 1, 1);
        checks++; if (lives !== 3'd1) begin failures++; $display("FAIL hitbonus_lives: got %0d want 1", lives); end
        checks++; if (invincible !== 1'b1) begin failures++; $display("FAIL hitbonus_inv: got %b want 1", invincible); end
        checks++; if (player_die !== 1'b0) begin failures++; $display("FAIL hitbonus_die: got %b want 0", player_die); end
        cyc(0, 1, 0, 0, 1);
        checks++; if (lives !== 3'd2) begin failures++; $display("FAIL invuln_bonus: got %0d want 2", lives); end
        run_ticks(P_INV);
    endtask

    task automatic test_blink();
        logic [4:0] want;
        want = 5'b10011;  // bit k: visible after tick k
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        checks++; if (visible !== want[0]) begin failures++; $display("FAIL blink_t0: got %b want %b", visible, want[0]); end
        for (int k = 1; k <= 4; k++) begin
            run_ticks(1);
            checks++; if (visible !== want[k]) begin failures++; $display("FAIL blink_t%0d: got %b want %b", k, visible, want[k]); end
        end
        cyc(0, 1, 1, 0, 0);
        checks++; if (visible !== 1'b1) begin failures++; $display("FAIL blink_alive: got %b want 1", visible); end
    endtask

    task automatic test_reset_mid();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        run_ticks(1);
        cyc(1, 1, 1, 1, 1);
        checks++; if (invincible !== 1'b0) begin failures++; $display("FAIL rstmid_inv: got %b want 0", invincible); end
        checks++; if (lives !== 3'd3) begin failures++; $display("FAIL rstmid_lives: got %0d want 3", lives); end
        cyc(0, 1, 0, 0, 0);
        checks++; if (invincible !== 1'b1) begin failures++; $display("FAIL rstmid_reenter: got %b want 1", invincible); end
    endtask

    task automatic test_random();
        int r, ga, tk, h, b;
        cyc(0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 255) == 0) ? 1 : 0;
            ga = ($urandom_range(0, 79) != 0) ? 1 : 0;
            tk = ($urandom_range(0, 2) == 0) ? 1 : 0;
            h  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            b  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            cyc(r, ga, tk, h, b);
            checks++; if (lives !== 3'(m_lives)) begin failures++; $display("FAIL rnd_lives@%0d: got %0d want %0d", n, lives, m_lives); end
            checks++; if (player_die !== (m_mode == 3)) begin failures++; $display("FAIL rnd_die@%0d: got %b want %b", n, player_die, m_mode == 3); end
            checks++; if (invincible !== (m_mode == 1)) begin failures++; $display("FAIL rnd_inv@%0d: got %b want %b", n, invincible, m_mode == 1); end
            checks++; if (visible !== (m_vis != 0)) begin failures++; $display("FAIL rnd_vis@%0d: got %b want %0d", n, visible, m_vis); end
        end
    endtask

    initial begin
        test_reset();
        test_spawn();
        test_hit();
        test_held_hit();
        test_death();
        test_bonus_sat();
        test_blink();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
